// File: rtl/life_scan_ctrl_pkg.sv
// rtl/life_scan_ctrl_pkg.sv - shared constants and encodings for the life array scan controller
package life_scan_ctrl_pkg;

  // Scan chain length (4x4 board) and the shift counter width that covers it
  localparam int LIFE_CELLS = 16;
  localparam int LIFE_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_t;

  // LOAD inserts a new pattern (and still captures the displaced board); READ recirculates
  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_READ = 1'b1
  } scan_mode_t;

endpackage

// File: rtl/life_scan_ctrl_if.sv
// rtl/life_scan_ctrl_if.sv - host-side request/response bundle of the scan controller
interface life_scan_ctrl_if #(
  parameter int CELLS = life_scan_ctrl_pkg::LIFE_CELLS
);

  logic             load_req;
  logic             read_req;
  logic [CELLS-1:0] load_data;
  logic             run_in;
  logic             busy;
  logic             done;
  logic [CELLS-1:0] read_data;
  logic             run;

  // Host side: issues requests and the generation-enable request
  modport master (
    output load_req,
    output read_req,
    output load_data,
    output run_in,
    input  busy,
    input  done,
    input  read_data,
    input  run
  );

  // Controller side
  modport slave (
    input  load_req,
    input  read_req,
    input  load_data,
    input  run_in,
    output busy,
    output done,
    output read_data,
    output run
  );

endinterface

// File: rtl/life_scan_ctrl_shift_reg.sv
// rtl/life_scan_ctrl_shift_reg.sv - parallel-load, serial-in/serial-out shift register
module life_scan_ctrl_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  // Clear dominates, then parallel load, then shift toward the MSB taking sin at the LSB
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/life_scan_ctrl.sv
// rtl/life_scan_ctrl.sv - scan chain driver: loads or non-destructively reads the life board
module life_scan_ctrl
  import life_scan_ctrl_pkg::*;
#(
  parameter int CELLS = LIFE_CELLS,
  parameter int CNT_W = LIFE_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  life_scan_ctrl_if.slave        bus,
  output logic                   scan,
  output logic                   scan_write_enb,
  output logic                   scan_write_val,
  input  logic                   scan_read_val
);

  scan_state_t      state_q;
  scan_state_t      state_d;
  scan_mode_t       mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CELLS-1:0] sreg;
  logic [CELLS-1:0] read_data_q;
  logic             accept;
  logic             last_shift;

  // Requests are only taken while idle; anything arriving mid-operation is dropped
  assign accept     = (state_q == ST_IDLE) && (bus.load_req || bus.read_req);
  assign last_shift = (count_q == CNT_W'(CELLS - 1));

  // The shift register is loaded with the new pattern on a load accept and captures the
  // chain tail on every shift cycle, so it ends holding the displaced board either way
  life_scan_ctrl_shift_reg #(
    .W (CELLS)
  ) u_sreg (
    .clk      (clk),
    .clr_n    (reset),
    .load     (accept && bus.load_req),
    .load_val (bus.load_data),
    .shift    (state_q == ST_SHIFT),
    .sin      (scan_read_val),
    .q        (sreg)
  );

  // State register, shift counter, mode latch and readback capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_LOAD;
      count_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q <= '0;
        mode_q  <= bus.load_req ? MODE_LOAD : MODE_READ;
      end else if (state_q == ST_SHIFT) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (state_q == ST_DONE) begin
        read_data_q <= sreg;
      end
    end
  end

  // Next-state: one accept cycle, CELLS shift cycles, one done cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state; run is gated off for the whole operation
  always_comb begin
    scan           = 1'b0;
    scan_write_enb = 1'b0;
    scan_write_val = 1'b0;
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = (state_q == ST_DONE);
    bus.read_data  = read_data_q;
    bus.run        = bus.run_in && (state_q == ST_IDLE);
    if (state_q == ST_SHIFT) begin
      scan = 1'b1;
      if (mode_q == MODE_LOAD) begin
        scan_write_enb = 1'b1;
        scan_write_val = sreg[CELLS-1];
      end
    end
  end

endmodule

// File: tb/tb_life_scan_ctrl.sv
// tb/tb_life_scan_ctrl.sv - self-checking bench for the life array scan controller
module tb_life_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan;
  logic        scan_write_enb;
  logic        scan_write_val;
  logic        scan_read_val;
  logic [15:0] arr = 16'h0000;

  int checks = 0;
  int failures = 0;
  int scan_cnt = 0;
  int done_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  life_scan_ctrl_if bus ();

  life_scan_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .scan           (scan),
    .scan_write_enb (scan_write_enb),
    .scan_write_val (scan_write_val),
    .scan_read_val  (scan_read_val)
  );

  // Array stand-in: a 16-cell chain whose tail is cell 15
  assign scan_read_val = arr[15];
  always @(posedge clk) begin
    if (scan === 1'b1) arr <= {arr[14:0], (scan_write_enb ? scan_write_val : arr[15])};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model: an accepted request opens a 17-cycle window (16 shifts + done)
  bit          m_active = 1'b0;
  int          m_k = 0;
  bit          m_load = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic [15:0] m_prior = 16'h0;
  logic [15:0] m_board = 16'h0;
  bit          m_board_known = 1'b1;
  logic [15:0] m_rd = 16'h0;
  bit          m_rd_known = 1'b1;

  always @(posedge clk) begin
    if (!reset) begin
      if (m_active) m_board_known = 1'b0;
      m_active   = 1'b0;
      m_rd       = 16'h0;
      m_rd_known = 1'b1;
    end else if (m_active) begin
      if (m_k == 16) begin
        m_active   = 1'b0;
        m_rd       = m_prior;
        m_rd_known = m_board_known;
        if (m_load) begin
          m_board       = m_data;
          m_board_known = 1'b1;
        end
      end else begin
        m_k++;
      end
    end else if (bus.load_req || bus.read_req) begin
      m_active = 1'b1;
      m_k      = 0;
      m_load   = bus.load_req;
      m_data   = bus.load_data;
      m_prior  = m_board;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      logic e_scan, e_done, e_enb, e_val, e_busy;
      e_busy = m_active;
      e_scan = m_active && (m_k < 16);
      e_done = m_active && (m_k == 16);
      e_enb  = e_scan && m_load;
      e_val  = e_enb ? m_data[15 - m_k] : 1'b0;
      chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      chk("done", {31'd0, bus.done}, {31'd0, e_done});
      chk("scan", {31'd0, scan}, {31'd0, e_scan});
      chk("scan_write_enb", {31'd0, scan_write_enb}, {31'd0, e_enb});
      chk("scan_write_val", {31'd0, scan_write_val}, {31'd0, e_val});
      chk("run", {31'd0, bus.run}, {31'd0, bus.run_in & ~e_busy});
      if (m_rd_known) chk("read_data", {16'd0, bus.read_data}, {16'd0, m_rd});
      if (scan === 1'b1) scan_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic do_op(input bit l, input bit r, input logic [15:0] d, input string tag);
    int lat;
    @(posedge clk); #1;
    bus.load_req = l; bus.read_req = r; bus.load_data = d;
    scan_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    bus.load_req = 1'b0; bus.read_req = 1'b0;
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) break;
    end
    chk({tag, "_latency"}, lat, 18);
    chk({tag, "_scan_cycles"}, scan_cnt, 16);
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_run_back"}, {31'd0, bus.run}, {31'd0, bus.run_in});
  endtask

  initial begin
    bus.load_req = 1'b0; bus.read_req = 1'b0; bus.load_data = 16'h0; bus.run_in = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_scan", {31'd0, scan}, 32'd0);
    chk("rst_read_data", {16'd0, bus.read_data}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    do_op(1'b1, 1'b0, 16'h6600, "load6600");
    chk("alive_6600", {16'd0, arr}, 32'h6600);

    do_op(1'b0, 1'b1, 16'h0000, "read");
    chk("read_6600", {16'd0, bus.read_data}, 32'h6600);
    chk("alive_kept", {16'd0, arr}, 32'h6600);

    do_op(1'b1, 1'b0, 16'h0001, "load0001");
    do_op(1'b1, 1'b0, 16'h6186, "load6186");
    chk("alive_6186", {16'd0, arr}, 32'h6186);
    chk("displaced_0001", {16'd0, bus.read_data}, 32'h0001);

    // Simultaneous load+read, then a stray read request mid-shift
    @(posedge clk); #1;
    bus.load_req = 1'b1; bus.read_req = 1'b1; bus.load_data = 16'hA5C3;
    scan_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    bus.load_req = 1'b0; bus.read_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.read_req = 1'b1;
    @(posedge clk); #1 bus.read_req = 1'b0;
    repeat (25) @(negedge clk);
    chk("both_done_once", done_cnt, 1);
    chk("both_scan_cycles", scan_cnt, 16);
    chk("both_alive", {16'd0, arr}, 32'hA5C3);
    chk("both_read_data", {16'd0, bus.read_data}, 32'h6186);

    // run gating across a load
    bus.run_in = 1'b1;
    @(negedge clk);
    chk("run_idle", {31'd0, bus.run}, 32'd1);
    do_op(1'b1, 1'b0, 16'h1234, "load1234");
    chk("alive_1234", {16'd0, arr}, 32'h1234);

    // Reset during shift cycle 7 aborts with no done pulse
    @(posedge clk); #1;
    bus.load_req = 1'b1; bus.load_data = 16'hFFFF;
    @(posedge clk); #1;
    bus.load_req = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    done_cnt = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_scan", {31'd0, scan}, 32'd0);
    chk("abort_read_data", {16'd0, bus.read_data}, 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
